player_shot_ctrl: RTL and testbench

//  Sequences the single player shot: fire-key edge detect, launch handshake with the shot mover,

---
 rtl/player_shot_ctrl_if.sv | 27 ++
 rtl/player_shot_ctrl.sv | 160 ++++++++++++++++
 tb/tb_player_shot_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/player_shot_ctrl_if.sv
// Signal bundle between the player-shot controller and its keypad/mover/score neighbours.
// The master side is the controller itself; the slave side is the surrounding environment.
interface player_shot_ctrl_if;
  logic               startOfFrame;
  logic               playGame;
  logic               fireKey;
  logic               shotAlive;
  logic signed [10:0] shotTopLeftY;
  logic               hitAlien;
  logic               hitShield;
  logic               shotStart;
  logic               shotKill;
  logic               alienHitPulse;
  logic               explodeActive;
  logic        [7:0]  shotsFired;
  logic               launchError;

  modport master (
    input  startOfFrame, playGame, fireKey, shotAlive, shotTopLeftY, hitAlien, hitShield,
    output shotStart, shotKill, alienHitPulse, explodeActive, shotsFired, launchError
  );

  modport slave (
    output startOfFrame, playGame, fireKey, shotAlive, shotTopLeftY, hitAlien, hitShield,
    input  shotStart, shotKill, alienHitPulse, explodeActive, shotsFired, launchError
  );
endinterface

// File: rtl/player_shot_ctrl.sv
// Player shot sequencer: fire edge detect, launch handshake, flight supervision,
// explosion hold and re-fire cooldown. All outputs are registered.
module player_shot_ctrl #(
  parameter int TOP_LIMIT       = 16,
  parameter int EXPLODE_FRAMES  = 8,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int LAUNCH_TIMEOUT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  player_shot_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_FLYING, S_EXPLODE, S_COOLDOWN
  } state_t;

  localparam logic signed [10:0] TOP_Y   = 11'(TOP_LIMIT);
  localparam logic [3:0]         WAIT_LAST = 4'(LAUNCH_TIMEOUT - 1);
  localparam logic [7:0]         EX_LAST = 8'(EXPLODE_FRAMES - 1);
  localparam logic [7:0]         CD_LAST = (COOLDOWN_FRAMES == 0) ? 8'd0 : 8'(COOLDOWN_FRAMES - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       first_q, first_d;
  logic       fire_key_q, fire_key_d;
  logic       shot_start_q, shot_start_d;
  logic       shot_kill_q, shot_kill_d;
  logic       alien_hit_q, alien_hit_d;
  logic       explode_q, explode_d;
  logic [7:0] shots_fired_q, shots_fired_d;
  logic       launch_error_q, launch_error_d;
  logic       fire_edge;

  assign fire_edge = bus.fireKey & ~fire_key_q;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    first_d        = 1'b0;
    fire_key_d     = bus.fireKey;
    shot_start_d   = 1'b0;
    shot_kill_d    = 1'b0;
    alien_hit_d    = 1'b0;
    shots_fired_d  = shots_fired_q;
    launch_error_d = launch_error_q;

    if (!bus.playGame) begin
      state_d        = S_IDLE;
      wait_cnt_d     = '0;
      frame_cnt_d    = '0;
      shots_fired_d  = '0;
      launch_error_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fire_edge) begin
            state_d       = S_LAUNCH;
            shot_start_d  = 1'b1;
            shots_fired_d = (shots_fired_q == 8'hFF) ? shots_fired_q : shots_fired_q + 8'd1;
          end
        end
        S_LAUNCH: begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
        S_WAIT: begin
          if (bus.shotAlive) begin
            state_d = S_FLYING;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d        = S_IDLE;
            launch_error_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        S_FLYING: begin
          // Hits outrank a same-cycle top exit so only one kill is ever issued.
          if (bus.hitAlien || bus.hitShield) begin
            state_d     = S_EXPLODE;
            shot_kill_d = 1'b1;
            alien_hit_d = bus.hitAlien;
            frame_cnt_d = '0;
            first_d     = 1'b1;
          end else if (bus.startOfFrame && (bus.shotTopLeftY < TOP_Y)) begin
            state_d     = S_COOLDOWN;
            shot_kill_d = 1'b1;
            frame_cnt_d = '0;
            first_d     = 1'b1;
          end else if (!bus.shotAlive) begin
            state_d     = S_COOLDOWN;
            frame_cnt_d = '0;
            first_d     = 1'b1;
          end
        end
        S_EXPLODE: begin
          // first_q masks a frame pulse landing on the state's first cycle.
          if (bus.startOfFrame && !first_q) begin
            if (frame_cnt_q == EX_LAST) begin
              state_d     = S_COOLDOWN;
              frame_cnt_d = '0;
              first_d     = 1'b1;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        S_COOLDOWN: begin
          if (COOLDOWN_FRAMES == 0) begin
            state_d = S_IDLE;
          end else if (bus.startOfFrame && !first_q) begin
            if (frame_cnt_q == CD_LAST) state_d = S_IDLE;
            else frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    explode_d = (state_d == S_EXPLODE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wait_cnt_q     <= '0;
      frame_cnt_q    <= '0;
      first_q        <= 1'b0;
      fire_key_q     <= 1'b0;
      shot_start_q   <= 1'b0;
      shot_kill_q    <= 1'b0;
      alien_hit_q    <= 1'b0;
      explode_q      <= 1'b0;
      shots_fired_q  <= '0;
      launch_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      first_q        <= first_d;
      fire_key_q     <= fire_key_d;
      shot_start_q   <= shot_start_d;
      shot_kill_q    <= shot_kill_d;
      alien_hit_q    <= alien_hit_d;
      explode_q      <= explode_d;
      shots_fired_q  <= shots_fired_d;
      launch_error_q <= launch_error_d;
    end
  end

  assign bus.shotStart     = shot_start_q;
  assign bus.shotKill      = shot_kill_q;
  assign bus.alienHitPulse = alien_hit_q;
  assign bus.explodeActive = explode_q;
  assign bus.shotsFired    = shots_fired_q;
  assign bus.launchError   = launch_error_q;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Directed bench for player_shot_ctrl: per-cycle vector table plus hand-written
// sequences for explosion/cooldown timing, saturation and asynchronous reset.
module tb_player_shot_ctrl;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  player_shot_ctrl_if bif ();

  player_shot_ctrl #(
    .TOP_LIMIT      (16),
    .EXPLODE_FRAMES (8),
    .COOLDOWN_FRAMES(4),
    .LAUNCH_TIMEOUT (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sof, play, fire, alive;
    int         y;
    logic       ha, hs;
    logic       e_start, e_kill, e_alien, e_exp;
    int         e_fired;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit sof, bit play, bit fire, bit alive, int y, bit ha, bit hs,
                              bit es, bit ek, bit ea, bit ex, int ef, bit er);
    vec_t v;
    v.sof = sof; v.play = play; v.fire = fire; v.alive = alive; v.y = y;
    v.ha = ha; v.hs = hs; v.e_start = es; v.e_kill = ek; v.e_alien = ea;
    v.e_exp = ex; v.e_fired = ef; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch_fly();
    bif.fireKey = 1'b1;
    step();
    chk("launch start", int'(bif.shotStart), 1);
    bif.fireKey = 1'b0;
    step();
    bif.shotAlive = 1'b1;
    step();
  endtask

  initial begin
    int kills, aliens;

    bif.startOfFrame = 1'b0; bif.playGame = 1'b1; bif.fireKey = 1'b0; bif.shotAlive = 1'b0;
    bif.shotTopLeftY = 11'sd100; bif.hitAlien = 1'b0; bif.hitShield = 1'b0;
    reset = 1'b1;

    // sof play fire alive y ha hs | start kill alien exp fired err
    vecs.push_back(mk(0,1,1,0,100,0,0, 1,0,0,0,1,0));  // 0 fire edge -> launch
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,1,0));  // 1 held key
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,1,0));  // 2 wait
    vecs.push_back(mk(0,1,1,1,100,0,0, 0,0,0,0,1,0));  // 3 alive -> flying
    vecs.push_back(mk(1,1,1,1,100,0,0, 0,0,0,0,1,0));  // 4 frame, high on screen
    vecs.push_back(mk(1,1,1,1, 16,0,0, 0,0,0,0,1,0));  // 5 Y at limit stays
    vecs.push_back(mk(0,1,1,1, 15,0,0, 0,0,0,0,1,0));  // 6 no frame pulse
    vecs.push_back(mk(1,1,1,1, 15,0,0, 0,1,0,0,1,0));  // 7 top exit -> kill
    vecs.push_back(mk(1,1,1,0,100,0,0, 0,0,0,0,1,0));  // 8 entry-cycle frame ignored
    vecs.push_back(mk(1,1,1,0,100,0,0, 0,0,0,0,1,0));  // 9 cooldown frame 1
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,1,0));  // 10
    vecs.push_back(mk(1,1,1,0,100,0,0, 0,0,0,0,1,0));  // 11 frame 2
    vecs.push_back(mk(1,1,1,0,100,0,0, 0,0,0,0,1,0));  // 12 frame 3
    vecs.push_back(mk(0,1,0,0,100,0,0, 0,0,0,0,1,0));  // 13 release
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,1,0));  // 14 edge in cooldown dropped
    vecs.push_back(mk(1,1,0,0,100,0,0, 0,0,0,0,1,0));  // 15 frame 4 -> idle
    vecs.push_back(mk(0,1,1,0,100,0,0, 1,0,0,0,2,0));  // 16 edge accepted
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,2,0));  // 17 -> wait
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,2,0));  // 18 wait 1
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,2,0));  // 19 wait 2
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,2,0));  // 20 wait 3
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,2,1));  // 21 wait 4 -> error
    vecs.push_back(mk(0,1,1,0,100,0,0, 0,0,0,0,2,1));  // 22 sticky
    vecs.push_back(mk(0,0,1,0,100,0,0, 0,0,0,0,0,0));  // 23 abort clears
    vecs.push_back(mk(0,1,0,0,100,0,0, 0,0,0,0,0,0));  // 24

    step();
    chk("reset start", int'(bif.shotStart), 0);
    chk("reset kill", int'(bif.shotKill), 0);
    chk("reset alien", int'(bif.alienHitPulse), 0);
    chk("reset explode", int'(bif.explodeActive), 0);
    chk("reset fired", int'(bif.shotsFired), 0);
    chk("reset error", int'(bif.launchError), 0);
    #3 reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      bif.startOfFrame = vecs[i].sof; bif.playGame = vecs[i].play; bif.fireKey = vecs[i].fire;
      bif.shotAlive = vecs[i].alive; bif.shotTopLeftY = 11'(vecs[i].y);
      bif.hitAlien = vecs[i].ha; bif.hitShield = vecs[i].hs;
      step();
      chk($sformatf("vec%0d start", i), int'(bif.shotStart), int'(vecs[i].e_start));
      chk($sformatf("vec%0d kill", i), int'(bif.shotKill), int'(vecs[i].e_kill));
      chk($sformatf("vec%0d alien", i), int'(bif.alienHitPulse), int'(vecs[i].e_alien));
      chk($sformatf("vec%0d explode", i), int'(bif.explodeActive), int'(vecs[i].e_exp));
      chk($sformatf("vec%0d fired", i), int'(bif.shotsFired), vecs[i].e_fired);
      chk($sformatf("vec%0d error", i), int'(bif.launchError), int'(vecs[i].e_err));
    end
    bif.startOfFrame = 1'b0; bif.shotTopLeftY = 11'sd100;

    // Level alien hit lasting 5 cycles, then explosion and cooldown timing.
    launch_fly();
    bif.hitAlien = 1'b1;
    kills = 0; aliens = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) chk("hit explode", int'(bif.explodeActive), 1);
      kills += int'(bif.shotKill);
      aliens += int'(bif.alienHitPulse);
    end
    chk("level hit kills", kills, 1);
    chk("level hit alien pulses", aliens, 1);
    bif.hitAlien = 1'b0; bif.shotAlive = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bif.startOfFrame = 1'b1;
      step();
      bif.startOfFrame = 1'b0;
      chk($sformatf("explode frame%0d", i + 1), int'(bif.explodeActive), (i < 7) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      bif.fireKey = 1'b1;
      step();
      chk($sformatf("cooldown fire%0d", i), int'(bif.shotStart), 0);
      bif.fireKey = 1'b0;
      bif.startOfFrame = 1'b1;
      step();
      bif.startOfFrame = 1'b0;
    end
    bif.fireKey = 1'b1;
    step();
    chk("post cooldown start", int'(bif.shotStart), 1);
    chk("post cooldown fired", int'(bif.shotsFired), 2);
    bif.fireKey = 1'b0;
    step();
    bif.shotAlive = 1'b1;
    step();

    // Shield hit coincident with a top exit: hit wins.
    bif.hitShield = 1'b1; bif.startOfFrame = 1'b1; bif.shotTopLeftY = 11'sd10;
    step();
    chk("shield+top kill", int'(bif.shotKill), 1);
    chk("shield+top alien", int'(bif.alienHitPulse), 0);
    chk("shield+top explode", int'(bif.explodeActive), 1);
    bif.hitShield = 1'b0; bif.startOfFrame = 1'b0; bif.shotTopLeftY = 11'sd100;
    step();
    chk("shield+top kill once", int'(bif.shotKill), 0);
    bif.playGame = 1'b0;
    step();
    chk("abort explode", int'(bif.explodeActive), 0);
    chk("abort fired", int'(bif.shotsFired), 0);
    bif.playGame = 1'b1;

    // Mover drops alive with no event: silent move to cooldown.
    launch_fly();
    bif.shotAlive = 1'b0;
    step();
    chk("alive drop kill", int'(bif.shotKill), 0);
    chk("alive drop explode", int'(bif.explodeActive), 0);
    bif.fireKey = 1'b1;
    step();
    chk("alive drop no refire", int'(bif.shotStart), 0);
    bif.fireKey = 1'b0; bif.playGame = 1'b0;
    step();
    bif.playGame = 1'b1;

    // Saturation over 256 launches exiting off the top (negative Y).
    for (int i = 0; i < 256; i++) begin
      launch_fly();
      chk($sformatf("sat fired%0d", i), int'(bif.shotsFired), (i < 255) ? i + 1 : 255);
      bif.shotTopLeftY = -11'sd5; bif.startOfFrame = 1'b1;
      step();
      bif.startOfFrame = 1'b0; bif.shotAlive = 1'b0; bif.shotTopLeftY = 11'sd100;
      step();
      repeat (4) begin
        bif.startOfFrame = 1'b1;
        step();
        bif.startOfFrame = 1'b0;
      end
    end

    launch_fly();
    bif.hitAlien = 1'b1; bif.hitShield = 1'b1;
    kills = 0; aliens = 0;
    repeat (3) begin
      step();
      kills += int'(bif.shotKill);
      aliens += int'(bif.alienHitPulse);
    end
    chk("double hit kills", kills, 1);
    chk("double hit alien pulses", aliens, 1);
    chk("saturated fired", int'(bif.shotsFired), 255);
    bif.hitAlien = 1'b0; bif.hitShield = 1'b0;

    // Asynchronous reset in the cycle the kill pulse is high.
    bif.playGame = 1'b0;
    step();
    bif.playGame = 1'b1;
    launch_fly();
    bif.hitAlien = 1'b1;
    step();
    chk("pre reset kill", int'(bif.shotKill), 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset kill", int'(bif.shotKill), 0);
    chk("async reset alien", int'(bif.alienHitPulse), 0);
    chk("async reset explode", int'(bif.explodeActive), 0);
    chk("async reset fired", int'(bif.shotsFired), 0);
    chk("async reset start", int'(bif.shotStart), 0);
    bif.hitAlien = 1'b0;
    #2 reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
